// File: rtl/result_packetizer_pkg.sv
// ============================================================================
// Module      : result_packetizer_pkg
// Description : Host-link framing constants and FSM state type, shared by the
//               result packetizer (TX) and the float/fixed input collector (RX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_packetizer_pkg;

    localparam logic [1:0] APP_FLOAT = 2'b01;
    localparam logic [1:0] APP_FIX   = 2'b10;

    localparam logic [2:0] SZ_1W     = 3'b001;
    localparam logic [2:0] SZ_2W32   = 3'b010;
    localparam logic [2:0] SZ_2W40   = 3'b011;

    localparam logic [2:0] PKT_ONLY  = 3'b000;
    localparam logic [2:0] PKT_HI    = 3'b001;
    localparam logic [2:0] PKT_LO    = 3'b010;

    // MSB positions of the {app, size, packet, data} fields in a 48-bit word
    localparam int APP_MSB  = 47;
    localparam int SIZE_MSB = 45;
    localparam int PKT_MSB  = 42;
    localparam int DATA_MSB = 39;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [1:0] app, input logic [2:0] size);
        return ((app == APP_FLOAT) || (app == APP_FIX)) &&
               ((size == SZ_1W) || (size == SZ_2W32) || (size == SZ_2W40));
    endfunction

    function automatic logic is_two_beat(input logic [2:0] size);
        return (size == SZ_2W32) || (size == SZ_2W40);
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_packetizer_formatter.sv
// ============================================================================
// Module      : result_packetizer_formatter
// Description : Combinational builder of one framed host-link word for a given
//               beat of a captured result, plus a legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_packetizer_formatter
    import result_packetizer_pkg::*;
#(
    parameter int INT_WID   = 40,
    parameter int FREC_WID  = 40,
    parameter int FLOAT_WID = 80,
    parameter int DATAOUT   = 48,
    parameter int APP       = 2,
    parameter int SIZE      = 3
) (
    input  logic [APP-1:0]       app_i,
    input  logic [SIZE-1:0]      size_i,
    input  logic                 beat2_i,
    input  logic [INT_WID-1:0]   int_i,
    input  logic [FREC_WID-1:0]  frec_i,
    input  logic [FLOAT_WID-1:0] float_i,
    output logic [DATAOUT-1:0]   word_o,
    output logic                 legal_o
);

    localparam int DW = DATAOUT - APP - SIZE - 3;

    logic [DW-1:0] data_w;
    logic [2:0]    pkt_w;

    always_comb begin
        data_w  = '0;
        pkt_w   = PKT_ONLY;
        legal_o = is_legal(app_i, size_i);
        if (is_two_beat(size_i)) begin
            pkt_w = beat2_i ? PKT_LO : PKT_HI;
        end
        // Narrow payloads are left-justified in the data field, low bits zero
        case (app_i)
            APP_FLOAT: begin
                if (size_i == SZ_1W) begin
                    data_w[DW-1 -: 32] = float_i[31:0];
                end else if (is_two_beat(size_i)) begin
                    data_w = beat2_i ? float_i[DW-1:0] : float_i[2*DW-1:DW];
                end
            end
            APP_FIX: begin
                case (size_i)
                    SZ_1W: begin
                        data_w[DW-1  -: 16] = int_i[15:0];
                        data_w[DW-17 -: 16] = frec_i[15:0];
                    end
                    SZ_2W32: data_w[DW-1 -: 32] = beat2_i ? frec_i[31:0] : int_i[31:0];
                    SZ_2W40: data_w = beat2_i ? frec_i[DW-1:0] : int_i[DW-1:0];
                    default: data_w = '0;
                endcase
            end
            default: data_w = '0;
        endcase
        word_o = {app_i, size_i, pkt_w, data_w};
    end

endmodule

`default_nettype wire

// File: rtl/result_packetizer.sv
// ============================================================================
// Module      : result_packetizer
// Description : Serialises float or fixed-point conversion results into one or
//               two 48-bit host-link words with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_packetizer
    import result_packetizer_pkg::*;
#(
    parameter int INT_WID   = 40,
    parameter int FREC_WID  = 40,
    parameter int FLOAT_WID = 80,
    parameter int DATAOUT   = 48,
    parameter int APP       = 2,
    parameter int SIZE      = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [APP-1:0]       in_app,
    input  logic [SIZE-1:0]      in_size,
    input  logic [INT_WID-1:0]   in_int,
    input  logic [FREC_WID-1:0]  in_frec,
    input  logic [FLOAT_WID-1:0] in_float,
    output logic [DATAOUT-1:0]   dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 err,
    output logic                 busy
);

    state_e                 state_q, state_d;
    logic [APP-1:0]         app_q;
    logic [SIZE-1:0]        size_q;
    logic [INT_WID-1:0]     int_q;
    logic [FREC_WID-1:0]    frec_q;
    logic [FLOAT_WID-1:0]   float_q;
    logic                   err_q, err_d;
    logic                   cap_en_w;
    logic [DATAOUT-1:0]     word_w;
    logic                   legal_w;

    always_comb begin
        state_d  = state_q;
        cap_en_w = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_en_w = 1'b1;
                    if (is_legal(in_app, in_size)) begin
                        state_d = ST_BEAT1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (dout_ready) begin
                    state_d = is_two_beat(size_q) ? ST_BEAT2 : ST_IDLE;
                end
            end
            ST_BEAT2: begin
                if (dout_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            app_q   <= '0;
            size_q  <= '0;
            int_q   <= '0;
            frec_q  <= '0;
            float_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (cap_en_w) begin
                app_q   <= in_app;
                size_q  <= in_size;
                int_q   <= in_int;
                frec_q  <= in_frec;
                float_q <= in_float;
            end
        end
    end

    result_packetizer_formatter #(
        .INT_WID   (INT_WID),
        .FREC_WID  (FREC_WID),
        .FLOAT_WID (FLOAT_WID),
        .DATAOUT   (DATAOUT),
        .APP       (APP),
        .SIZE      (SIZE)
    ) u_formatter (
        .app_i   (app_q),
        .size_i  (size_q),
        .beat2_i (state_q == ST_BEAT2),
        .int_i   (int_q),
        .frec_i  (frec_q),
        .float_i (float_q),
        .word_o  (word_w),
        .legal_o (legal_w)
    );

    // dout is decoded from the frozen capture registers, so it cannot move while
    // a beat is stalled and it drops to zero the instant reset forces IDLE.
    assign dout       = (state_q != ST_IDLE) && legal_w ? word_w : '0;
    assign dout_valid = (state_q != ST_IDLE);
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

`default_nettype wire
